attn_dot_mac: RTL
=================

// Module: attn_dot_mac
// PURPOSE
//   Parametrised streaming dot-product engine for the attention score path.
//   Accepts signed operand pairs (a0,b0,a1,b1,...) on one valid/ready slave stream.
//   Accumulates N_FEAT products and emits one scaled, clipped score per vector on a valid/ready master stream.
//   Sits between the Q/K operand feeder and the softmax stage.
// PARAMETERS
//   DATA_W   8   operand width, signed two's complement
//   N_FEAT   4   products per vector (>=1)
//   OUT_W    8   score width, signed
//   SHIFT    0   arithmetic right shift applied to the accumulator before clipping (0..ACC_W-1)
//   SAT      1   1: saturate to OUT_W signed range; 0: truncate to low OUT_W bits
//   ACC_W    localparam = 2*DATA_W + $clog2(N_FEAT); accumulator width, no internal overflow
// PORTS
//   clk       in   1        clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   in_data   in   DATA_W   operand; a and b alternate, a first
//   in_vld    in   1        slave valid
//   in_rdy    out  1        slave ready
//   out_data  out  OUT_W    score
//   out_sat   out  1        score was clipped (SAT=1 only, else 0)
//   out_vld   out  1        master valid
//   out_rdy   in   1        master ready
//   busy      out  1        high from first a-handshake until score handshake
// BEHAVIOUR
//   Reset (async, rst_n=0): state=GET_A, acc=0, cnt=0, a_reg=0; out_data=0, out_sat=0, out_vld=0, busy=0; in_rdy=1 after release.
//   Transfer occurs on any rising edge with vld&rdy both high; no other cycle changes state.
//   FSM:
//     GET_A: in_rdy=1; on handshake a_reg<=in_data, busy<=1 -> GET_B.
//     GET_B: in_rdy=1; on handshake acc<=acc+a_reg*in_data (signed, full 2*DATA_W product, sign-extended to ACC_W).
//            If cnt==N_FEAT-1: load output regs, cnt<=0 -> OUT; else cnt<=cnt+1 -> GET_A.
//     OUT:   in_rdy=0, out_vld=1; out_data/out_sat held stable; on out_rdy: out_vld<=0, acc<=0, busy<=0 -> GET_A.
//   Output computation, from the final acc including the last product:
//     s = (acc_final) >>> SHIFT.
//     SAT=1: clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat=1 iff clipped.
//     SAT=0: low OUT_W bits of s; out_sat=0.
//   Latency: out_vld rises the cycle after the final b-handshake.
//   in_rdy is combinational from state only (never from in_vld/out_rdy); out_vld is registered.
//   Idle input (in_vld=0) in GET_A/GET_B: hold all state indefinitely, no partial output.
//   Back-to-back: after out handshake, GET_A accepts a new a on the very next edge; acc starts from 0.
//   N_FEAT=1: a single pair produces a score; cnt is held at 0.
//   Reset mid-vector or mid-OUT: partial accumulation and pending score are discarded; the next vector is computed fresh.
//   in_data is don't-care when in_vld=0; out_data is stable but meaningless when out_vld=0.
// TESTING (defaults unless stated)
//   pairs (1,2)(3,4)(5,6)(7,8), out_rdy=1 -> out_data=100, out_sat=0, out_vld 1 cycle after 8th in handshake, asserted 1 cycle.
//   4x(-128,-128) -> acc=65536 -> out_data=127, out_sat=1; with SAT=0 -> out_data=0, out_sat=0.
//   4x(-1,100) -> -400 -> out_data=-128, out_sat=1; with SHIFT=2 and OUT_W=10 -> out_data=-100, out_sat=0.
//   out_rdy=0 for 5 cycles after score -> out_vld and out_data stay constant, in_rdy=0; next vector (1,1)x4 -> 4.
//   random in_vld gaps (including between a and b) and random out_rdy over 200 vectors -> all scores match the reference model.
//   rst_n pulsed low after 3 handshakes (async, mid-cycle) -> outputs 0 immediately; then (2,3)x4 -> 24.

Source files
------------

// File: rtl/attn_dot_mac.sv
// Streaming signed dot-product engine for the attention score path.
// Operands arrive as alternating a/b words on a valid/ready slave stream; after
// N_FEAT products the accumulator is shifted, clipped or truncated, and the
// resulting score is held on a valid/ready master stream until it is accepted.
module attn_dot_mac #(
  parameter int DATA_W = 8,
  parameter int N_FEAT = 4,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_FEAT);
  localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  // One bit wider than both the accumulator and the score so the clip limits
  // and the shifted value compare without wrapping for any OUT_W/ACC_W mix.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {GET_A, GET_B, OUT} state_t;

  state_t                    state, state_nxt;
  logic signed [DATA_W-1:0]  a_reg;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_final;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [EXT_W-1:0]   s_ext;
  logic [CNT_W-1:0]          cnt;
  logic [OUT_W-1:0]          score;
  logic                      clip;
  logic                      in_hs;
  logic                      last;

  assign in_hs = in_vld & in_rdy;
  assign last  = (cnt == CNT_W'(N_FEAT-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GET_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and slave ready; ready depends on state only.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    case (state)
      GET_A: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = GET_B;
      end
      GET_B: begin
        in_rdy = 1'b1;
        if (in_vld) state_nxt = last ? OUT : GET_A;
      end
      OUT: begin
        if (out_rdy) state_nxt = GET_A;
      end
      default: state_nxt = GET_A;
    endcase
  end

  // Product, running sum including the current product, and score formatting.
  always_comb begin
    prod      = (2*DATA_W)'(a_reg) * (2*DATA_W)'($signed(in_data));
    acc_final = acc + ACC_W'(prod);
    shifted   = acc_final >>> SHIFT;
    s_ext     = EXT_W'(shifted);
    score     = s_ext[OUT_W-1:0];
    clip      = 1'b0;
    if (SAT != 0) begin
      if (s_ext > MAX_V) begin
        score = MAX_V[OUT_W-1:0];
        clip  = 1'b1;
      end else if (s_ext < MIN_V) begin
        score = MIN_V[OUT_W-1:0];
        clip  = 1'b1;
      end
    end
  end

  // Operand capture, accumulation, feature counter and registered score outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (in_hs) begin
            a_reg <= $signed(in_data);
            busy  <= 1'b1;
          end
        end
        GET_B: begin
          if (in_hs) begin
            acc <= acc_final;
            if (last) begin
              cnt      <= '0;
              out_data <= score;
              out_sat  <= clip;
              out_vld  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (out_rdy) begin
            out_vld <= 1'b0;
            acc     <= '0;
            busy    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
